// File: rtl/bp_resolve_unit_if.sv
// Bundle of the ifu prediction, exu resolution, bpu update and perf signals
// around bp_resolve_unit; slave is the resolve unit's view.
`ifndef BP_ADDR_BITS
`define BP_ADDR_BITS 32
`endif
`ifndef BP_ADDR_DEPTH
`define BP_ADDR_DEPTH 16
`endif

interface bp_resolve_unit_if #(
    parameter int N_ADDR_BITS  = `BP_ADDR_BITS,
    parameter int N_DATA_BITS  = 32,
    parameter int N_DEPTH_BITS = `BP_ADDR_DEPTH,
    parameter int N_ADDR_W     = $clog2(N_DEPTH_BITS)
);
    logic                   pred_valid;
    logic                   pred_ready;
    logic [N_ADDR_BITS-1:0] pred_pc;
    logic                   pred_match;
    logic [N_ADDR_W-1:0]    pred_addr;
    logic                   pred_taken;
    logic [N_DATA_BITS-1:0] pred_target;

    logic                   res_valid;
    logic                   res_ready;
    logic                   res_is_br;
    logic                   res_taken;
    logic [N_DATA_BITS-1:0] res_target;
    logic                   res_kill;

    logic                   flush_valid;
    logic                   flush_new_pc;
    logic                   flush_type;
    logic [N_ADDR_W-1:0]    flush_addr;
    logic [N_ADDR_BITS-1:0] flush_bp_pc;
    logic [N_DATA_BITS-1:0] flush_pc;

    logic                   redirect_valid;
    logic [N_DATA_BITS-1:0] redirect_pc;
    logic [31:0]            perf_br_cnt;
    logic [31:0]            perf_miss_cnt;

    modport slave (
        input  pred_valid, pred_pc, pred_match, pred_addr, pred_taken, pred_target,
        input  res_valid, res_is_br, res_taken, res_target, res_kill,
        output pred_ready, res_ready,
        output flush_valid, flush_new_pc, flush_type, flush_addr, flush_bp_pc, flush_pc,
        output redirect_valid, redirect_pc, perf_br_cnt, perf_miss_cnt
    );

    modport master (
        output pred_valid, pred_pc, pred_match, pred_addr, pred_taken, pred_target,
        output res_valid, res_is_br, res_taken, res_target, res_kill,
        input  pred_ready, res_ready,
        input  flush_valid, flush_new_pc, flush_type, flush_addr, flush_bp_pc, flush_pc,
        input  redirect_valid, redirect_pc, perf_br_cnt, perf_miss_cnt
    );
endinterface

// File: rtl/bp_resolve_unit.sv
// Pairs queued branch predictions with in-order exu resolutions, trains or
// allocates bpu entries and redirects the ifu on mispredicts.
`ifndef BP_ADDR_BITS
`define BP_ADDR_BITS 32
`endif
`ifndef BP_ADDR_DEPTH
`define BP_ADDR_DEPTH 16
`endif

module bp_resolve_unit #(
    parameter int N_ADDR_BITS  = `BP_ADDR_BITS,
    parameter int N_DATA_BITS  = 32,
    parameter int N_DEPTH_BITS = `BP_ADDR_DEPTH,
    parameter int N_ADDR_W     = $clog2(N_DEPTH_BITS),
    parameter int N_QDEPTH     = 4
) (
    input logic               clk,
    input logic               rstn,
    bp_resolve_unit_if.slave  bus
);
    localparam int QW = $clog2(N_QDEPTH);

    typedef struct packed {
        logic [N_ADDR_BITS-1:0] pc;
        logic                   match;
        logic [N_ADDR_W-1:0]    addr;
        logic                   taken;
        logic [N_DATA_BITS-1:0] target;
    } rec_t;

    rec_t q_mem_q [N_QDEPTH];
    logic [QW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QW:0]   cnt_q, cnt_d;

    logic                   flush_valid_q, flush_valid_d;
    logic                   flush_new_pc_q, flush_new_pc_d;
    logic                   flush_type_q, flush_type_d;
    logic [N_ADDR_W-1:0]    flush_addr_q, flush_addr_d;
    logic [N_ADDR_BITS-1:0] flush_bp_pc_q, flush_bp_pc_d;
    logic [N_DATA_BITS-1:0] flush_pc_q, flush_pc_d;
    logic                   redirect_valid_q, redirect_valid_d;
    logic [N_DATA_BITS-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]            perf_br_cnt_q, perf_br_cnt_d;
    logic [31:0]            perf_miss_cnt_q, perf_miss_cnt_d;

    logic pred_ready, res_ready, enq, deq, tgt_diff, mispred;
    rec_t head;

    always_comb begin
        pred_ready = (cnt_q != (QW+1)'(N_QDEPTH));
        res_ready  = (cnt_q != '0) && !bus.res_kill;
        enq        = bus.pred_valid && pred_ready;
        deq        = bus.res_valid && res_ready;
        head       = q_mem_q[rd_ptr_q];
        tgt_diff   = bus.res_taken && head.taken && (head.target != bus.res_target);
        mispred    = deq && (bus.res_is_br ? ((head.taken != bus.res_taken) || tgt_diff)
                                           : head.taken);
    end

    // Kill and mispredict both discard every queued record, including any enqueue this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.res_kill || mispred) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + QW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + QW'(1);
            cnt_d = cnt_q + (QW+1)'(enq) - (QW+1)'(deq);
        end
    end

    always_comb begin
        flush_valid_d    = 1'b0;
        flush_new_pc_d   = flush_new_pc_q;
        flush_type_d     = flush_type_q;
        flush_addr_d     = flush_addr_q;
        flush_bp_pc_d    = flush_bp_pc_q;
        flush_pc_d       = flush_pc_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        perf_br_cnt_d    = perf_br_cnt_q;
        perf_miss_cnt_d  = perf_miss_cnt_q;
        if (deq) begin
            // A taken branch whose target the bpu cannot supply needs a fresh entry.
            if (bus.res_is_br && bus.res_taken && (!head.match || tgt_diff)) begin
                flush_valid_d  = 1'b1;
                flush_new_pc_d = 1'b1;
                flush_type_d   = 1'b1;
                flush_bp_pc_d  = head.pc;
                flush_pc_d     = bus.res_target;
            end else if (head.match) begin
                flush_valid_d  = 1'b1;
                flush_new_pc_d = 1'b0;
                flush_type_d   = bus.res_is_br && bus.res_taken;
                flush_addr_d   = head.addr;
            end
            if (bus.res_is_br && perf_br_cnt_q != '1) perf_br_cnt_d = perf_br_cnt_q + 32'd1;
        end
        if (mispred) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = bus.res_taken ? bus.res_target
                                             : N_DATA_BITS'(head.pc) + N_DATA_BITS'(4);
            if (perf_miss_cnt_q != '1) perf_miss_cnt_d = perf_miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) q_mem_q[wr_ptr_q] <= '{pc: bus.pred_pc, match: bus.pred_match,
                                        addr: bus.pred_addr, taken: bus.pred_taken,
                                        target: bus.pred_target};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
            flush_valid_q    <= 1'b0;
            flush_new_pc_q   <= 1'b0;
            flush_type_q     <= 1'b0;
            flush_addr_q     <= '0;
            flush_bp_pc_q    <= '0;
            flush_pc_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            perf_br_cnt_q    <= '0;
            perf_miss_cnt_q  <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
            flush_valid_q    <= flush_valid_d;
            flush_new_pc_q   <= flush_new_pc_d;
            flush_type_q     <= flush_type_d;
            flush_addr_q     <= flush_addr_d;
            flush_bp_pc_q    <= flush_bp_pc_d;
            flush_pc_q       <= flush_pc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            perf_br_cnt_q    <= perf_br_cnt_d;
            perf_miss_cnt_q  <= perf_miss_cnt_d;
        end
    end

    assign bus.pred_ready     = pred_ready;
    assign bus.res_ready      = res_ready;
    assign bus.flush_valid    = flush_valid_q;
    assign bus.flush_new_pc   = flush_new_pc_q;
    assign bus.flush_type     = flush_type_q;
    assign bus.flush_addr     = flush_addr_q;
    assign bus.flush_bp_pc    = flush_bp_pc_q;
    assign bus.flush_pc       = flush_pc_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.perf_br_cnt    = perf_br_cnt_q;
    assign bus.perf_miss_cnt  = perf_miss_cnt_q;
endmodule

// File: tb/tb_bp_resolve_unit.sv
// Bench for bp_resolve_unit: directed vector table, multi-cycle corner
// sequences, and a randomized run against a queue-based reference model.
module tb_bp_resolve_unit;
    localparam int AB = 32, DB = 32, DEP = 16, AW = 4, QD = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bp_resolve_unit_if #(.N_ADDR_BITS(AB), .N_DATA_BITS(DB), .N_DEPTH_BITS(DEP), .N_ADDR_W(AW)) bus();

    bp_resolve_unit #(.N_ADDR_BITS(AB), .N_DATA_BITS(DB), .N_DEPTH_BITS(DEP),
                      .N_ADDR_W(AW), .N_QDEPTH(QD)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pred_valid = 0; bus.pred_pc = '0; bus.pred_match = 0; bus.pred_addr = '0;
        bus.pred_taken = 0; bus.pred_target = '0;
        bus.res_valid = 0; bus.res_is_br = 0; bus.res_taken = 0; bus.res_target = '0;
        bus.res_kill = 0;
    endtask

    task automatic set_pred(input logic [31:0] pc, input logic m, input logic [3:0] a,
                            input logic t, input logic [31:0] tg);
        bus.pred_valid = 1; bus.pred_pc = pc; bus.pred_match = m; bus.pred_addr = a;
        bus.pred_taken = t; bus.pred_target = tg;
    endtask

    task automatic set_res(input logic br, input logic t, input logic [31:0] tg);
        bus.res_valid = 1; bus.res_is_br = br; bus.res_taken = t; bus.res_target = tg;
    endtask

    task automatic enq(input logic [31:0] pc, input logic m, input logic [3:0] a,
                       input logic t, input logic [31:0] tg);
        set_pred(pc, m, a, t, tg);
        tick();
        bus.pred_valid = 0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 0;
        tick();
        tick();
        rstn = 1;
    endtask

    typedef struct {
        logic [31:0] pc; logic m; logic [3:0] a; logic pt; logic [31:0] ptg;
        logic br; logic rt; logic [31:0] rtg;
        logic fv; logic np; logic ty; logic [3:0] fa; logic [31:0] fbp; logic [31:0] fpc;
        logic rv; logic [31:0] rpc;
    } vec_t;
    vec_t tbl[10];

    typedef struct { logic [31:0] pc; logic m; logic [3:0] a; logic t; logic [31:0] tg; } rec_t;
    rec_t mq[$];

    initial begin
        logic [31:0] exp_br, exp_miss;
        tbl[0] = '{32'h100, 1, 4'd2, 1, 32'h200, 1, 1, 32'h200, 1, 0, 1, 4'd2, 0, 0, 0, 0};
        tbl[1] = '{32'h104, 0, 4'd0, 0, 32'h0,   1, 1, 32'h300, 1, 1, 1, 0, 32'h104, 32'h300, 1, 32'h300};
        tbl[2] = '{32'h40,  1, 4'd5, 1, 32'h80,  1, 0, 32'h0,   1, 0, 0, 4'd5, 0, 0, 1, 32'h44};
        tbl[3] = '{32'h50,  1, 4'd3, 1, 32'h90,  1, 1, 32'ha0,  1, 1, 1, 0, 32'h50, 32'ha0, 1, 32'ha0};
        tbl[4] = '{32'h60,  0, 4'd0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{32'h70,  1, 4'd7, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 4'd7, 0, 0, 0, 0};
        tbl[6] = '{32'h74,  1, 4'd1, 1, 32'h100, 0, 0, 32'h0,   1, 0, 0, 4'd1, 0, 0, 1, 32'h78};
        tbl[7] = '{32'h78,  0, 4'd0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{32'h7c,  1, 4'd4, 0, 32'h0,   1, 1, 32'h120, 1, 0, 1, 4'd4, 0, 0, 1, 32'h120};
        tbl[9] = '{32'hfffffffc, 0, 4'd0, 1, 32'h10, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h0};

        do_reset();
        chk("rst_pred_ready", bus.pred_ready, 1);
        chk("rst_res_ready", bus.res_ready, 0);
        chk("rst_flush_valid", bus.flush_valid, 0);
        chk("rst_redirect", bus.redirect_valid, 0);
        chk("rst_flush_pc", bus.flush_pc, 0);
        chk("rst_br_cnt", bus.perf_br_cnt, 0);
        chk("rst_miss_cnt", bus.perf_miss_cnt, 0);

        // Table: one prediction then its resolution, outputs checked the following cycle.
        exp_br = 0; exp_miss = 0;
        for (int i = 0; i < 10; i++) begin
            enq(tbl[i].pc, tbl[i].m, tbl[i].a, tbl[i].pt, tbl[i].ptg);
            set_res(tbl[i].br, tbl[i].rt, tbl[i].rtg);
            tick();
            idle();
            exp_br += 32'(tbl[i].br);
            exp_miss += 32'(tbl[i].rv);
            chk($sformatf("t%0d_flush_valid", i), bus.flush_valid, tbl[i].fv);
            if (tbl[i].fv) begin
                chk($sformatf("t%0d_new_pc", i), bus.flush_new_pc, tbl[i].np);
                chk($sformatf("t%0d_type", i), bus.flush_type, tbl[i].ty);
                if (tbl[i].np) begin
                    chk($sformatf("t%0d_bp_pc", i), bus.flush_bp_pc, tbl[i].fbp);
                    chk($sformatf("t%0d_flush_pc", i), bus.flush_pc, tbl[i].fpc);
                end else begin
                    chk($sformatf("t%0d_addr", i), bus.flush_addr, tbl[i].fa);
                end
            end
            chk($sformatf("t%0d_redirect", i), bus.redirect_valid, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("t%0d_redirect_pc", i), bus.redirect_pc, tbl[i].rpc);
            chk($sformatf("t%0d_res_ready", i), bus.res_ready, 0);
        end
        chk("tbl_br_cnt", bus.perf_br_cnt, exp_br);
        chk("tbl_miss_cnt", bus.perf_miss_cnt, exp_miss);

        // Fill, simultaneous enq+deq at count 3, then kill.
        for (int i = 0; i < 4; i++) enq(32'h200 + 32'(4*i), 0, 4'd0, 0, 32'h0);
        chk("full_pred_ready", bus.pred_ready, 0);
        chk("full_res_ready", bus.res_ready, 1);
        set_res(0, 0, 32'h0);
        tick();
        idle();
        chk("deq_pred_ready", bus.pred_ready, 1);
        chk("deq_no_flush", bus.flush_valid, 0);
        set_pred(32'h210, 0, 4'd0, 0, 32'h0);
        set_res(0, 0, 32'h0);
        #1;
        chk("both_res_ready", bus.res_ready, 1);
        tick();
        idle();
        chk("cnt3_pred_ready", bus.pred_ready, 1);
        enq(32'h214, 0, 4'd0, 0, 32'h0);
        chk("refill_pred_ready", bus.pred_ready, 0);
        bus.res_kill = 1;
        set_res(1, 1, 32'h900);
        set_pred(32'h218, 0, 4'd0, 0, 32'h0);
        #1;
        chk("kill_res_ready", bus.res_ready, 0);
        tick();
        idle();
        chk("post_kill_res_ready", bus.res_ready, 0);
        chk("post_kill_pred_ready", bus.pred_ready, 1);
        chk("kill_no_flush", bus.flush_valid, 0);
        chk("kill_no_redirect", bus.redirect_valid, 0);

        // Mispredict with younger records and a same-cycle enqueue.
        enq(32'h300, 1, 4'd6, 0, 32'h0);
        enq(32'h304, 0, 4'd0, 0, 32'h0);
        enq(32'h308, 0, 4'd0, 0, 32'h0);
        set_pred(32'h30c, 0, 4'd0, 0, 32'h0);
        set_res(1, 1, 32'h500);
        #1;
        chk("mp_pred_ready", bus.pred_ready, 1);
        tick();
        idle();
        chk("mp_redirect", bus.redirect_valid, 1);
        chk("mp_redirect_pc", bus.redirect_pc, 32'h500);
        chk("mp_flush_valid", bus.flush_valid, 1);
        chk("mp_new_pc", bus.flush_new_pc, 0);
        chk("mp_addr", bus.flush_addr, 6);
        chk("mp_type", bus.flush_type, 1);
        chk("mp_empty", bus.res_ready, 0);
        tick();
        chk("mp_redirect_pulse", bus.redirect_valid, 0);
        chk("mp_flush_pulse", bus.flush_valid, 0);

        // Asynchronous reset between a mispredicting handshake and its clock edge.
        enq(32'h10, 0, 4'd0, 0, 32'h0);
        set_res(1, 1, 32'h700);
        #2;
        rstn = 0;
        #1;
        chk("arst_res_ready", bus.res_ready, 0);
        chk("arst_redirect", bus.redirect_valid, 0);
        chk("arst_miss_cnt", bus.perf_miss_cnt, 0);
        idle();
        tick();
        rstn = 1;
        tick();
        chk("arst_no_flush", bus.flush_valid, 0);
        chk("arst_no_redirect", bus.redirect_valid, 0);
        chk("arst_redirect_pc", bus.redirect_pc, 0);

        // Randomized run against the reference queue model.
        begin
            logic e_np, e_ty, e_fv, e_rv;
            logic [3:0] e_fa;
            logic [31:0] e_fbp, e_fpc, e_rpc, m_br, m_miss;
            logic [31:0] tgts[4];
            tgts[0] = 32'h100; tgts[1] = 32'h200; tgts[2] = 32'h300; tgts[3] = 32'hfffffff0;
            do_reset();
            mq.delete();
            e_np = 0; e_ty = 0; e_fa = 0; e_fbp = 0; e_fpc = 0; e_rpc = 0; m_br = 0; m_miss = 0;
            for (int c = 0; c < 3000; c++) begin
                logic exp_pr, exp_rr, do_enq, do_deq, mis, tgt_ok, alloc;
                rec_t h, n;
                idle();
                n.pc = ($urandom_range(0, 9) == 0) ? 32'hfffffffc : 32'($urandom_range(0, 63)) << 2;
                n.m = 1'($urandom); n.a = 4'($urandom); n.t = 1'($urandom);
                n.tg = tgts[$urandom_range(0, 3)];
                if ($urandom_range(0, 2) != 0) set_pred(n.pc, n.m, n.a, n.t, n.tg);
                if ($urandom_range(0, 1) != 0)
                    set_res(1'($urandom_range(0, 3) != 0), 1'($urandom), tgts[$urandom_range(0, 3)]);
                bus.res_kill = ($urandom_range(0, 24) == 0);
                #1;
                exp_pr = (mq.size() < QD);
                exp_rr = (mq.size() > 0) && !bus.res_kill;
                chk("rnd_pred_ready", bus.pred_ready, exp_pr);
                chk("rnd_res_ready", bus.res_ready, exp_rr);
                do_enq = bus.pred_valid && exp_pr;
                do_deq = bus.res_valid && exp_rr;
                e_fv = 0; e_rv = 0; mis = 0;
                if (do_deq) begin
                    h = mq[0];
                    if (bus.res_is_br) mis = (h.t != bus.res_taken) || (h.t && bus.res_taken && h.tg != bus.res_target);
                    else mis = h.t;
                    // bpu's answer is usable if it hit and, when it predicted taken, gave the right target
                    tgt_ok = h.m && !(h.t && h.tg != bus.res_target);
                    alloc = bus.res_is_br && bus.res_taken && !tgt_ok;
                    if (alloc) begin
                        e_fv = 1; e_np = 1; e_ty = 1; e_fbp = h.pc; e_fpc = bus.res_target;
                    end else if (h.m) begin
                        e_fv = 1; e_np = 0; e_fa = h.a; e_ty = bus.res_is_br ? bus.res_taken : 1'b0;
                    end
                    if (mis) begin
                        e_rv = 1;
                        e_rpc = bus.res_taken ? bus.res_target : h.pc + 32'd4;
                        if (m_miss != 32'hffffffff) m_miss++;
                    end
                    if (bus.res_is_br && m_br != 32'hffffffff) m_br++;
                end
                if (bus.res_kill || mis) mq.delete();
                else begin
                    if (do_deq) void'(mq.pop_front());
                    if (do_enq) mq.push_back(n);
                end
                tick();
                chk("rnd_flush_valid", bus.flush_valid, e_fv);
                chk("rnd_new_pc", bus.flush_new_pc, e_np);
                chk("rnd_type", bus.flush_type, e_ty);
                chk("rnd_addr", bus.flush_addr, e_fa);
                chk("rnd_bp_pc", bus.flush_bp_pc, e_fbp);
                chk("rnd_flush_pc", bus.flush_pc, e_fpc);
                chk("rnd_redirect", bus.redirect_valid, e_rv);
                chk("rnd_redirect_pc", bus.redirect_pc, e_rpc);
                chk("rnd_br_cnt", bus.perf_br_cnt, m_br);
                chk("rnd_miss_cnt", bus.perf_miss_cnt, m_miss);
            end
        end

        // Counter saturation: preload the counters next to the ceiling.
        do_reset();
        enq(32'h20, 0, 4'd0, 0, 32'h0);
        force dut.perf_br_cnt_q = 32'hfffffffe;
        force dut.perf_miss_cnt_q = 32'hffffffff;
        set_res(1, 1, 32'h40);
        #1;
        chk("sat_br_step", dut.perf_br_cnt_d, 32'hffffffff);
        chk("sat_miss_hold", dut.perf_miss_cnt_d, 32'hffffffff);
        force dut.perf_br_cnt_q = 32'hffffffff;
        #1;
        chk("sat_br_hold", dut.perf_br_cnt_d, 32'hffffffff);
        chk("sat_br_out", bus.perf_br_cnt, 32'hffffffff);
        release dut.perf_br_cnt_q;
        release dut.perf_miss_cnt_q;
        idle();
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
